// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, the queued command
// record and the sequencer FSM states.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [2:0]           op;
    logic                 ci;
    logic                 chain;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  // Only add and sub produce a carry worth chaining into the next byte.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, registered occupancy count, head always
// visible on dout. Push when full or pop when empty is ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  cmd_t        din,
  input  logic        pop,
  output cmd_t        dout,
  output logic [AW:0] count
);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives queued commands one at a time onto a combinational ALU, waits SETTLE
// cycles, captures result and flags, and returns them on a response stream.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_ci,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_fin,
  input  logic             alu_co,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_fin,
  output logic             rsp_co,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic [2:0]       rsp_op,
  output logic             carry_q,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_d;
  cmd_t        cmd_in, head;
  logic [AW:0] fifo_count;
  logic        fifo_empty;
  logic        pop, capture, release_rsp;
  logic [3:0]  cnt;

  assign cmd_in     = '{a: cmd_a, b: cmd_b, op: cmd_op, ci: cmd_ci, chain: cmd_chain};
  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = (fifo_count != (AW+1)'(DEPTH));
  assign busy       = !fifo_empty || (state != ST_IDLE);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (cnt == 4'd0) begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        release_rsp = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // alu_* only change on a pop, so the ALU sees stable operands between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_ci     <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_fin    <= '0;
      rsp_co     <= 1'b0;
      rsp_cf     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_op     <= '0;
      carry_q    <= 1'b0;
    end else begin
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
        alu_ci     <= head.chain ? carry_q : head.ci;
        cnt        <= 4'(SETTLE);
      end else if (state == ST_ISSUE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_fin   <= alu_fin;
        rsp_co    <= alu_co;
        rsp_cf    <= alu_cf;
        rsp_zf    <= alu_zf;
        rsp_op    <= alu_opcode;
        if (is_arith(alu_opcode)) carry_q <= alu_co;
      end
      if (release_rsp) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU stand-in, in-order command queue with a
// chained-carry model, directed scenarios plus a randomized backpressure run.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_ci, cmd_chain;
  logic [WIDTH-1:0] alu_a, alu_b, alu_fin;
  logic [2:0]       alu_opcode;
  logic             alu_ci, alu_co, alu_cf, alu_zf;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_fin;
  logic             rsp_co, rsp_cf, rsp_zf;
  logic [2:0]       rsp_op;
  logic             carry_q, busy;

  typedef struct packed {
    logic [7:0] f;
    logic       co;
    logic       cf;
    logic       zf;
  } alu_res_t;

  int total = 0;
  int bad   = 0;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_ci(cmd_ci), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
    .alu_fin(alu_fin), .alu_co(alu_co), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_fin(rsp_fin), .rsp_co(rsp_co), .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_op(rsp_op),
    .carry_q(carry_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sub is A + ~B + ci, so ci=1 means "no borrow in".
  function automatic alu_res_t alu_ref(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic ci);
    alu_res_t   r;
    logic [8:0] s;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + {8'd0, ci};
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      OP_XOR:  s = {1'b0, a ^ b};
      OP_GT:   s = {8'd0, a > b};
      OP_SHLA: s = {a, 1'b0};
      default: s = {b, 1'b0};
    endcase
    r.f  = s[7:0];
    r.co = s[8];
    r.cf = (op == OP_GT) ? (a > b) : s[8];
    r.zf = (s[7:0] == 8'd0);
    return r;
  endfunction

  alu_res_t alu_now;
  assign alu_now = alu_ref(alu_a, alu_b, alu_opcode, alu_ci);
  assign alu_fin = alu_now.f;
  assign alu_co  = alu_now.co;
  assign alu_cf  = alu_now.cf;
  assign alu_zf  = alu_now.zf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted commands in order, plus the chain carry.
  cmd_t       exp_q[$];
  logic       model_carry = 1'b0;
  logic [7:0] last_fin = 8'd0;
  int         n_sent = 0;
  int         n_rsp = 0;
  int         n_dropped = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic ci, input logic chain);
    int   n = 0;
    cmd_t c;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_ci = ci; cmd_chain = chain;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 0);
    @(posedge clk);
    c.a = a; c.b = b; c.op = op; c.ci = ci; c.chain = chain;
    exp_q.push_back(c);
    n_sent++;
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid) && n < 500) begin
      step();
      n++;
    end
    check("idle_bound", 32'(n < 500), 1);
  endtask

  // Response monitor: scoreboard on each handshake, stability check while stalled.
  logic       stall_seen = 1'b0;
  logic [13:0] stall_snap;
  cmd_t       mc;
  logic       mci;
  alu_res_t   mr;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", 32'(rsp_valid), 1);
        check("stall_hold", 32'({rsp_fin, rsp_co, rsp_cf, rsp_zf, rsp_op}), 32'(stall_snap));
      end
      stall_seen = rsp_valid && !rsp_ready;
      stall_snap = {rsp_fin, rsp_co, rsp_cf, rsp_zf, rsp_op};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_fin), 32'hFFFF_FFFF);
        end else begin
          mc  = exp_q.pop_front();
          mci = mc.chain ? model_carry : mc.ci;
          mr  = alu_ref(mc.a, mc.b, mc.op, mci);
          if (mc.op == OP_ADD || mc.op == OP_SUB) model_carry = mr.co;
          check("rsp_fin", 32'(rsp_fin), 32'(mr.f));
          check("rsp_flags", 32'({rsp_co, rsp_cf, rsp_zf}), 32'({mr.co, mr.cf, mr.zf}));
          check("rsp_op", 32'(rsp_op), 32'(mc.op));
          check("alu_drive", 32'({alu_a, alu_b, alu_opcode, alu_ci}),
                32'({mc.a, mc.b, mc.op, mci}));
          check("carry_q", 32'(carry_q), 32'(model_carry));
          last_fin = rsp_fin;
          n_rsp++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic       rand_run;
  logic [7:0] ra, rb;
  logic [2:0] rop;

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_ci = 1'b0; cmd_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_alu", 32'({alu_a, alu_b, alu_opcode, alu_ci}), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_fin, rsp_co, rsp_cf, rsp_zf, rsp_op}), 0);
    check("rst_carry", 32'(carry_q), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);

    // Single add: latency and result.
    rsp_ready = 1'b1;
    send(8'hF6, 8'h95, OP_ADD, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(SETTLE + 2));
    check("add_fin", 32'(rsp_fin), 32'h8B);
    check("add_co", 32'(rsp_co), 1);
    check("add_carry", 32'(carry_q), 1);
    wait_idle();

    // Two-byte chain.
    send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
    send(8'h00, 8'h00, OP_ADD, 1'b0, 1'b1);
    wait_idle();
    check("chain_fin", 32'(last_fin), 32'h01);
    check("chain_carry", 32'(carry_q), 0);

    // Back-to-back sub and logic ops.
    send(8'hF6, 8'h95, OP_SUB, 1'b1, 1'b0);
    send(8'hF6, 8'h95, OP_AND, 1'b0, 1'b0);
    send(8'hF6, 8'h95, OP_OR,  1'b0, 1'b0);
    send(8'hF6, 8'h95, OP_XOR, 1'b0, 1'b0);
    wait_idle();
    check("logic_last_fin", 32'(last_fin), 32'h63);
    check("logic_carry", 32'(carry_q), 1);

    // Backpressure: one in flight, four queued, sixth blocked.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      send(ra, rb, rop, 1'($urandom), 1'($urandom));
    end
    check("bp_full", 32'(cmd_ready), 0);
    fork
      send(8'h5A, 8'hA5, OP_SUB, 1'b0, 1'b1);
    join_none
    repeat (3) begin
      step();
      check("bp_ready_low", 32'(cmd_ready), 0);
    end
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    wait fork;
    wait_idle();

    // Randomized commands with random response backpressure.
    rand_run = 1'b1;
    fork
      begin
        logic [7:0] xa, xb;
        logic [2:0] xop;
        for (int i = 0; i < 40; i++) begin
          xa = 8'($urandom); xb = 8'($urandom); xop = 3'($urandom);
          send(xa, xb, xop, 1'($urandom), ($urandom_range(0, 2) == 0));
          if ($urandom_range(0, 3) == 0) step();
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          rsp_ready = ($urandom_range(0, 2) != 0);
          step();
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle();
    check("rand_drained", 32'(exp_q.size()), 0);

    // Reset during ISSUE with three commands still queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h10 + i), 8'h22, OP_ADD, 1'b1, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_queued", 32'(exp_q.size()), 4);
    rst = 1'b1;
    n_dropped = exp_q.size();
    exp_q.delete();
    model_carry = 1'b0;
    step();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    check("mid_rst_carry", 32'(carry_q), 0);
    rsp_ready = 1'b1;
    rst = 1'b0;
    repeat (8) step();
    check("post_rst_rsp_valid", 32'(rsp_valid), 0);
    check("post_rst_busy", 32'(busy), 0);

    check("rsp_count", 32'(n_rsp), 32'(n_sent - n_dropped));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
